// File: rtl/acc_pkg.sv
// Shared constants and types for the motion-estimation accelerator datapath.
package acc_pkg;

   localparam int RImgSize = 16;
   localparam int SImgSize = 31;
   localparam int Disp     = SImgSize - RImgSize + 1;
   localparam int PixW     = 8;
   localparam int SadW     = PixW + $clog2(RImgSize * RImgSize);

   typedef logic [SadW-1:0] sad_t;

   typedef enum logic [1:0] {
      SAD_IDLE  = 2'd0,
      SAD_RUN   = 2'd1,
      SAD_DRAIN = 2'd2
   } sad_state_e;

endpackage

// File: rtl/sad_pe.sv
// One SAD lane: absolute pixel difference feeding a load-or-accumulate register.
module sad_pe
   import acc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SAD_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [DATA_W-1:0] ref_pix,
   input  logic [DATA_W-1:0] srch_pix,
   output logic [SAD_W-1:0]  accum
);

   logic [DATA_W-1:0] abs_diff;
   logic [SAD_W-1:0]  diff_ext;

   always_comb begin
      abs_diff = (ref_pix >= srch_pix) ? (ref_pix - srch_pix) : (srch_pix - ref_pix);
      diff_ext = SAD_W'(abs_diff);
   end

   // load starts a new pass without a separate clear cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accum <= '0;
      end else if (en) begin
         accum <= load ? diff_ext : (accum + diff_ext);
      end
   end

endmodule

// File: rtl/sad_search_engine.sv
// Full-search block matcher: PE_NUM parallel SAD lanes, best-match scan, start/done.
// Optional per-candidate SAD stream enabled by defining SAD_ALL_OUT_EN.
module sad_search_engine
   import acc_pkg::*;
#(
   parameter  int DATA_W    = 8,
   parameter  int RIMG_SIZE = acc_pkg::RImgSize,
   parameter  int SIMG_SIZE = acc_pkg::SImgSize,
   parameter  int PE_NUM    = 8,
   localparam int DISP      = SIMG_SIZE - RIMG_SIZE + 1,
   localparam int REF_AW    = $clog2(RIMG_SIZE * RIMG_SIZE),
   localparam int SRCH_AW   = $clog2(SIMG_SIZE * SIMG_SIZE),
   localparam int SAD_W     = DATA_W + REF_AW,
   localparam int MV_W      = (DISP > 1) ? $clog2(DISP) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     rd_en_o,
   output logic [REF_AW-1:0]        ref_raddr_o,
   input  logic [DATA_W-1:0]        ref_data_i,
   output logic [SRCH_AW-1:0]       srch_raddr_o,
   input  logic [PE_NUM*DATA_W-1:0] srch_data_i,
   output logic [SAD_W-1:0]         best_sad_o,
   output logic [MV_W-1:0]          best_mvx_o,
   output logic [MV_W-1:0]          best_mvy_o,
`ifdef SAD_ALL_OUT_EN
   output logic                     sad_valid_o,
   output logic [SAD_W-1:0]         sad_o,
   output logic [MV_W-1:0]          sad_mvx_o,
   output logic [MV_W-1:0]          sad_mvy_o,
`endif
   output sad_state_e               state_o
);

   localparam int PIX_W      = (RIMG_SIZE > 1) ? $clog2(RIMG_SIZE) : 1;
   localparam int K_W        = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
   localparam int DRAIN_W    = $clog2(PE_NUM + 3);
   localparam int PIX_LAST   = RIMG_SIZE - 1;
   localparam int DX_LAST    = DISP - PE_NUM;
   localparam int DY_LAST    = DISP - 1;
   localparam int K_LAST     = PE_NUM - 1;
   localparam int DRAIN_LAST = PE_NUM + 2;

   if (DISP % PE_NUM != 0) begin : g_bad_pe_div
      $error("sad_search_engine: DISP (%0d) must be a multiple of PE_NUM (%0d)", DISP, PE_NUM);
   end
   if (PE_NUM > RIMG_SIZE * RIMG_SIZE) begin : g_bad_pe_num
      $error("sad_search_engine: PE_NUM (%0d) exceeds pixels per pass", PE_NUM);
   end

   // Valid/ready contract: start_i is a request sampled only in IDLE; done_o is a
   // single-cycle pulse and best_* are stable from it until the next accepted start.
   sad_state_e state_q, state_d;
   logic [DRAIN_W-1:0] drain_q;
   logic [PIX_W-1:0]   col_q, row_q;
   logic [MV_W-1:0]    dx0_q, dy_q;
   logic               issue, pass_first, pass_last, last_issue, accept;

   always_comb begin
      issue      = (state_q == SAD_RUN);
      accept     = (state_q == SAD_IDLE) && start_i;
      pass_first = (col_q == '0) && (row_q == '0);
      pass_last  = (col_q == PIX_W'(PIX_LAST)) && (row_q == PIX_W'(PIX_LAST));
      last_issue = pass_last && (dx0_q == MV_W'(DX_LAST)) && (dy_q == MV_W'(DY_LAST));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SAD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      rd_en_o = 1'b0;
      state_o = state_q;
      case (state_q)
         SAD_IDLE: begin
            if (start_i) state_d = SAD_RUN;
         end
         SAD_RUN: begin
            busy_o  = 1'b1;
            rd_en_o = 1'b1;
            if (last_issue) state_d = SAD_DRAIN;
         end
         SAD_DRAIN: begin
            busy_o = 1'b1;
            if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
               done_o  = 1'b1;
               state_d = SAD_IDLE;
            end
         end
         default: state_d = SAD_IDLE;
      endcase
   end

   // Loop nest: column, row, dx0 (by PE_NUM), dy. All wrap to zero after the last issue.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
         dx0_q <= '0;
         dy_q  <= '0;
      end else if (issue) begin
         if (col_q == PIX_W'(PIX_LAST)) begin
            col_q <= '0;
            if (row_q == PIX_W'(PIX_LAST)) begin
               row_q <= '0;
               if (dx0_q == MV_W'(DX_LAST)) begin
                  dx0_q <= '0;
                  dy_q  <= (dy_q == MV_W'(DY_LAST)) ? '0 : (dy_q + 1'b1);
               end else begin
                  dx0_q <= dx0_q + MV_W'(PE_NUM);
               end
            end else begin
               row_q <= row_q + 1'b1;
            end
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drain_q <= '0;
      end else if (state_q == SAD_DRAIN) begin
         drain_q <= drain_q + 1'b1;
      end else begin
         drain_q <= '0;
      end
   end

   always_comb begin
      ref_raddr_o  = REF_AW'(int'(row_q) * RIMG_SIZE + int'(col_q));
      srch_raddr_o = SRCH_AW'((int'(dy_q) + int'(row_q)) * SIMG_SIZE + int'(dx0_q) + int'(col_q));
   end

   // Control delayed by the one-cycle memory latency so it lines up with returning data.
   logic            vld_d, first_d, last_d;
   logic [MV_W-1:0] dx0_d, dy_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_d   <= 1'b0;
         first_d <= 1'b0;
         last_d  <= 1'b0;
         dx0_d   <= '0;
         dy_d    <= '0;
      end else begin
         vld_d   <= issue;
         first_d <= issue && pass_first;
         last_d  <= issue && pass_last;
         dx0_d   <= dx0_q;
         dy_d    <= dy_q;
      end
   end

   logic [SAD_W-1:0] accum [PE_NUM];

   for (genvar k = 0; k < PE_NUM; k++) begin : g_pe
      sad_pe #(
         .DATA_W (DATA_W),
         .SAD_W  (SAD_W)
      ) u_pe (
         .clk      (clk_i),
         .rst_n    (rst_ni),
         .en       (vld_d),
         .load     (first_d),
         .ref_pix  (ref_data_i),
         .srch_pix (srch_data_i[k*DATA_W +: DATA_W]),
         .accum    (accum[k])
      );
   end

   // snap_go marks the cycle in which accum[] holds a finished pass.
   logic             snap_go;
   logic [MV_W-1:0]  snap_dx0, snap_dy;
   logic [SAD_W-1:0] snap_q [PE_NUM];
   logic             scan_on;
   logic [K_W-1:0]   scan_k;
   logic [MV_W-1:0]  scan_dx0, scan_dy, scan_mvx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_go  <= 1'b0;
         snap_dx0 <= '0;
         snap_dy  <= '0;
      end else begin
         snap_go  <= vld_d && last_d;
         snap_dx0 <= dx0_d;
         snap_dy  <= dy_d;
      end
   end

   // A new snapshot overrides the end of the previous scan when both coincide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_on  <= 1'b0;
         scan_k   <= '0;
         scan_dx0 <= '0;
         scan_dy  <= '0;
         for (int k = 0; k < PE_NUM; k++) snap_q[k] <= '0;
      end else begin
         if (scan_on) begin
            if (scan_k == K_W'(K_LAST)) begin
               scan_on <= 1'b0;
               scan_k  <= '0;
            end else begin
               scan_k <= scan_k + 1'b1;
            end
         end
         if (snap_go) begin
            scan_on  <= 1'b1;
            scan_k   <= '0;
            scan_dx0 <= snap_dx0;
            scan_dy  <= snap_dy;
            for (int k = 0; k < PE_NUM; k++) snap_q[k] <= accum[k];
         end
      end
   end

   assign scan_mvx = scan_dx0 + MV_W'(scan_k);

   // Strict less-than keeps the earliest candidate in raster order on ties.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         best_sad_o <= '0;
         best_mvx_o <= '0;
         best_mvy_o <= '0;
      end else if (accept) begin
         best_sad_o <= '1;
         best_mvx_o <= '0;
         best_mvy_o <= '0;
      end else if (scan_on && (snap_q[scan_k] < best_sad_o)) begin
         best_sad_o <= snap_q[scan_k];
         best_mvx_o <= scan_mvx;
         best_mvy_o <= scan_dy;
      end
   end

`ifdef SAD_ALL_OUT_EN
   always_comb begin
      sad_valid_o = scan_on;
      sad_o       = scan_on ? snap_q[scan_k] : '0;
      sad_mvx_o   = scan_on ? scan_mvx : '0;
      sad_mvy_o   = scan_on ? scan_dy : '0;
   end
`else
   // Best-match-only build: the scanned candidates are consumed internally.
`endif

endmodule

// File: tb/tb_sad_search_engine.sv
// Self-checking bench for sad_search_engine: memory model, loop-nest address
// scoreboard and a brute-force SAD reference. Optional SAD_ALL_OUT_EN stream checked too.
`timescale 1ns/1ps
module tb_sad_search_engine;
   import acc_pkg::*;

   localparam int DATA_W   = 8;
   localparam int RS       = 16;
   localparam int SS       = 31;
   localparam int PE       = 8;
   localparam int DISP     = SS - RS + 1;
   localparam int N        = (DISP * DISP / PE) * RS * RS;
   localparam int DONE_CYC = N + PE + 3;
   localparam int LIMIT    = DONE_CYC + 200;

   logic                     clk, rst_ni, start_i;
   logic                     busy_o, done_o, rd_en_o;
   logic [7:0]               ref_raddr_o;
   logic [DATA_W-1:0]        ref_data_i;
   logic [9:0]               srch_raddr_o;
   logic [PE*DATA_W-1:0]     srch_data_i;
   logic [15:0]              best_sad_o;
   logic [3:0]               best_mvx_o, best_mvy_o;
   sad_state_e               state_o;
`ifdef SAD_ALL_OUT_EN
   logic                     sad_valid_o;
   logic [15:0]              sad_o;
   logic [3:0]               sad_mvx_o, sad_mvy_o;
`endif

   sad_search_engine #(
      .DATA_W(DATA_W), .RIMG_SIZE(RS), .SIMG_SIZE(SS), .PE_NUM(PE)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .rd_en_o      (rd_en_o),
      .ref_raddr_o  (ref_raddr_o),
      .ref_data_i   (ref_data_i),
      .srch_raddr_o (srch_raddr_o),
      .srch_data_i  (srch_data_i),
      .best_sad_o   (best_sad_o),
      .best_mvx_o   (best_mvx_o),
      .best_mvy_o   (best_mvy_o),
`ifdef SAD_ALL_OUT_EN
      .sad_valid_o  (sad_valid_o),
      .sad_o        (sad_o),
      .sad_mvx_o    (sad_mvx_o),
      .sad_mvy_o    (sad_mvy_o),
`endif
      .state_o      (state_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- memories (1-cycle read latency) ----------------
   logic [7:0] ref_mem  [RS*RS];
   logic [7:0] srch_mem [SS*SS];

   always @(posedge clk) begin
      if (rd_en_o) begin
         ref_data_i <= ref_mem[ref_raddr_o];
         for (int k = 0; k < PE; k++) begin
            if (int'(srch_raddr_o) + k < SS*SS)
               srch_data_i[k*DATA_W +: DATA_W] <= srch_mem[int'(srch_raddr_o) + k];
            else
               srch_data_i[k*DATA_W +: DATA_W] <= 8'd0;
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   int         model_sad [DISP*DISP];
   int         model_best, model_mvx, model_mvy;
   logic [17:0] exp_q [$];
   int         checks = 0;
   int         passed = 0;

   task automatic compute_model();
      model_best = -1;
      model_mvx  = 0;
      model_mvy  = 0;
      for (int dy = 0; dy < DISP; dy++) begin
         for (int dx = 0; dx < DISP; dx++) begin
            int s;
            s = 0;
            for (int r = 0; r < RS; r++)
               for (int c = 0; c < RS; c++) begin
                  int a, b;
                  a = int'(ref_mem[r*RS + c]);
                  b = int'(srch_mem[(dy + r)*SS + dx + c]);
                  s += (a > b) ? (a - b) : (b - a);
               end
            model_sad[dy*DISP + dx] = s;
            if (model_best < 0 || s < model_best) begin
               model_best = s;
               model_mvx  = dx;
               model_mvy  = dy;
            end
         end
      end
   endtask

   task automatic build_exp_q();
      exp_q.delete();
      for (int dy = 0; dy < DISP; dy++)
         for (int dx0 = 0; dx0 < DISP; dx0 += PE)
            for (int r = 0; r < RS; r++)
               for (int c = 0; c < RS; c++)
                  exp_q.push_back({8'(r*RS + c), 10'((dy + r)*SS + dx0 + c)});
   endtask

   task automatic fill_random();
      foreach (ref_mem[i])  ref_mem[i]  = 8'($urandom_range(0, 255));
      foreach (srch_mem[i]) srch_mem[i] = 8'($urandom_range(0, 255));
   endtask

   // ---------------- driver / monitor ----------------
   // Pulses start in cycle 0 and observes cycles 1.. until done+4 or stop_at.
   task automatic do_run(input int stop_at, input int xs_a, input int xs_b,
                         output int done_cyc, output int done_cnt, output int rd_cnt,
                         output int addr_err, output int busy_end,
                         output int beat_cnt, output int beat_err, output int beat_min);
      int cyc;
      logic [17:0] e;
      done_cyc = -1; done_cnt = 0; rd_cnt = 0; addr_err = 0; busy_end = 0;
      beat_cnt = 0; beat_err = 0; beat_min = 1 << 20;
      build_exp_q();
      @(negedge clk);
      start_i = 1'b1;
      cyc = 0;
      while (cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         start_i = (cyc == xs_a) || (cyc == xs_b);
         if (cyc == stop_at) return;
         if (rd_en_o) begin
            rd_cnt++;
            if (exp_q.size() == 0) addr_err++;
            else begin
               e = exp_q.pop_front();
               if ({ref_raddr_o, srch_raddr_o} !== e) addr_err++;
            end
         end
         if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
`ifdef SAD_ALL_OUT_EN
         if (sad_valid_o) begin
            if (beat_cnt >= DISP*DISP) beat_err++;
            else if (sad_o !== 16'(model_sad[beat_cnt]) ||
                     sad_mvx_o !== 4'(beat_cnt % DISP) ||
                     sad_mvy_o !== 4'(beat_cnt / DISP)) beat_err++;
            if (int'(sad_o) < beat_min) beat_min = int'(sad_o);
            beat_cnt++;
         end
`endif
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      end
      start_i  = 1'b0;
      busy_end = int'(busy_o);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_ni  = 1'b0;
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else passed++;
      checks++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else passed++;
      checks++; if (rd_en_o !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", rd_en_o); else passed++;
      checks++; if (ref_raddr_o !== 8'd0) $display("FAIL reset_ref_addr got=%0d exp=0", ref_raddr_o); else passed++;
      checks++; if (srch_raddr_o !== 10'd0) $display("FAIL reset_srch_addr got=%0d exp=0", srch_raddr_o); else passed++;
      checks++; if (best_sad_o !== 16'd0) $display("FAIL reset_best_sad got=%0d exp=0", best_sad_o); else passed++;
      checks++; if ({best_mvx_o, best_mvy_o} !== 8'd0) $display("FAIL reset_best_mv got=%0d,%0d exp=0,0", best_mvx_o, best_mvy_o); else passed++;
      checks++; if (state_o !== SAD_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_o, SAD_IDLE); else passed++;
`ifdef SAD_ALL_OUT_EN
      checks++; if ({sad_valid_o, sad_o, sad_mvx_o, sad_mvy_o} !== 25'd0) $display("FAIL reset_sad_stream got=%b exp=0", {sad_valid_o, sad_o, sad_mvx_o, sad_mvy_o}); else passed++;
`endif
      rst_ni = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_all_zero();
      int dc, dn, rc, ae, be, bc, br, bm;
      foreach (ref_mem[i])  ref_mem[i]  = 8'd0;
      foreach (srch_mem[i]) srch_mem[i] = 8'd0;
      compute_model();
      do_run(-1, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dc !== DONE_CYC) $display("FAIL zero_done_cycle got=%0d exp=%0d", dc, DONE_CYC); else passed++;
      checks++; if (dn !== 1) $display("FAIL zero_done_count got=%0d exp=1", dn); else passed++;
      checks++; if (rc !== N) $display("FAIL zero_rd_count got=%0d exp=%0d", rc, N); else passed++;
      checks++; if (ae !== 0) $display("FAIL zero_addr_seq got=%0d errors exp=0", ae); else passed++;
      checks++; if (be !== 0) $display("FAIL zero_busy_after got=%0d exp=0", be); else passed++;
      checks++; if (best_sad_o !== 16'd0) $display("FAIL zero_best_sad got=%0d exp=0", best_sad_o); else passed++;
      checks++; if ({best_mvx_o, best_mvy_o} !== 8'd0) $display("FAIL zero_best_mv got=%0d,%0d exp=0,0", best_mvx_o, best_mvy_o); else passed++;
   endtask

   task automatic test_planted_match();
      int dc, dn, rc, ae, be, bc, br, bm;
      fill_random();
      for (int r = 0; r < RS; r++)
         for (int c = 0; c < RS; c++)
            ref_mem[r*RS + c] = srch_mem[(5 + r)*SS + 11 + c];
      compute_model();
      do_run(-1, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dc !== DONE_CYC) $display("FAIL match_done_cycle got=%0d exp=%0d", dc, DONE_CYC); else passed++;
      checks++; if (best_sad_o !== 16'd0) $display("FAIL match_best_sad got=%0d exp=0", best_sad_o); else passed++;
      checks++; if (best_mvx_o !== 4'd11) $display("FAIL match_best_mvx got=%0d exp=11", best_mvx_o); else passed++;
      checks++; if (best_mvy_o !== 4'd5) $display("FAIL match_best_mvy got=%0d exp=5", best_mvy_o); else passed++;
      checks++; if (model_best != 0 || model_mvx != 11 || model_mvy != 5)
         $display("FAIL match_unique got=%0d@(%0d,%0d) exp=0@(11,5)", model_best, model_mvx, model_mvy); else passed++;
   endtask

   task automatic test_max_diff();
      int dc, dn, rc, ae, be, bc, br, bm;
      foreach (ref_mem[i])  ref_mem[i]  = 8'd255;
      foreach (srch_mem[i]) srch_mem[i] = 8'd0;
      compute_model();
      do_run(-1, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dn !== 1) $display("FAIL max_done_count got=%0d exp=1", dn); else passed++;
      checks++; if (best_sad_o !== 16'd65280) $display("FAIL max_best_sad got=%0d exp=65280", best_sad_o); else passed++;
      checks++; if ({best_mvx_o, best_mvy_o} !== 8'd0) $display("FAIL max_best_mv got=%0d,%0d exp=0,0", best_mvx_o, best_mvy_o); else passed++;
   endtask

   task automatic test_random();
      int dc, dn, rc, ae, be, bc, br, bm;
      fill_random();
      compute_model();
      do_run(-1, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dc !== DONE_CYC) $display("FAIL rand_done_cycle got=%0d exp=%0d", dc, DONE_CYC); else passed++;
      checks++; if (ae !== 0) $display("FAIL rand_addr_seq got=%0d errors exp=0", ae); else passed++;
      checks++; if (best_sad_o !== 16'(model_best)) $display("FAIL rand_best_sad got=%0d exp=%0d", best_sad_o, model_best); else passed++;
      checks++; if (best_mvx_o !== 4'(model_mvx) || best_mvy_o !== 4'(model_mvy))
         $display("FAIL rand_best_mv got=%0d,%0d exp=%0d,%0d", best_mvx_o, best_mvy_o, model_mvx, model_mvy); else passed++;
`ifdef SAD_ALL_OUT_EN
      checks++; if (bc !== DISP*DISP) $display("FAIL rand_beat_count got=%0d exp=%0d", bc, DISP*DISP); else passed++;
      checks++; if (br !== 0) $display("FAIL rand_beat_values got=%0d errors exp=0", br); else passed++;
      checks++; if (bm !== int'(best_sad_o)) $display("FAIL rand_beat_min got=%0d exp=%0d", bm, best_sad_o); else passed++;
`endif
   endtask

   task automatic test_extra_start();
      int dc, dn, rc, ae, be, bc, br, bm;
      fill_random();
      compute_model();
      do_run(-1, 100, DONE_CYC, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dn !== 1) $display("FAIL xstart_done_count got=%0d exp=1", dn); else passed++;
      checks++; if (dc !== DONE_CYC) $display("FAIL xstart_done_cycle got=%0d exp=%0d", dc, DONE_CYC); else passed++;
      checks++; if (rc !== N) $display("FAIL xstart_rd_count got=%0d exp=%0d", rc, N); else passed++;
      checks++; if (ae !== 0) $display("FAIL xstart_addr_seq got=%0d errors exp=0", ae); else passed++;
      checks++; if (be !== 0) $display("FAIL xstart_busy_after got=%0d exp=0", be); else passed++;
      checks++; if (best_sad_o !== 16'(model_best) || best_mvx_o !== 4'(model_mvx) || best_mvy_o !== 4'(model_mvy))
         $display("FAIL xstart_best got=%0d@(%0d,%0d) exp=%0d@(%0d,%0d)", best_sad_o, best_mvx_o, best_mvy_o,
                  model_best, model_mvx, model_mvy); else passed++;
   endtask

   task automatic test_reset_mid();
      int dc, dn, rc, ae, be, bc, br, bm;
      int stray_done;
      fill_random();
      compute_model();
      do_run(4000, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      rst_ni = 1'b0;
      #1;
      checks++; if ({busy_o, done_o, rd_en_o} !== 3'b000) $display("FAIL midrst_ctrl got=%b exp=000", {busy_o, done_o, rd_en_o}); else passed++;
      checks++; if (ref_raddr_o !== 8'd0 || srch_raddr_o !== 10'd0)
         $display("FAIL midrst_addr got=%0d,%0d exp=0,0", ref_raddr_o, srch_raddr_o); else passed++;
      checks++; if (best_sad_o !== 16'd0 || best_mvx_o !== 4'd0 || best_mvy_o !== 4'd0)
         $display("FAIL midrst_best got=%0d@(%0d,%0d) exp=0@(0,0)", best_sad_o, best_mvx_o, best_mvy_o); else passed++;
      stray_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done_o !== 1'b0) stray_done++;
      end
      rst_ni = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (done_o !== 1'b0 || busy_o !== 1'b0) stray_done++;
      end
      checks++; if (stray_done !== 0) $display("FAIL midrst_no_done got=%0d stray cycles exp=0", stray_done); else passed++;
      fill_random();
      compute_model();
      do_run(-1, -1, -1, dc, dn, rc, ae, be, bc, br, bm);
      checks++; if (dc !== DONE_CYC) $display("FAIL midrst_rerun_cycle got=%0d exp=%0d", dc, DONE_CYC); else passed++;
      checks++; if (ae !== 0) $display("FAIL midrst_rerun_addr got=%0d errors exp=0", ae); else passed++;
      checks++; if (best_sad_o !== 16'(model_best) || best_mvx_o !== 4'(model_mvx) || best_mvy_o !== 4'(model_mvy))
         $display("FAIL midrst_rerun_best got=%0d@(%0d,%0d) exp=%0d@(%0d,%0d)", best_sad_o, best_mvx_o, best_mvy_o,
                  model_best, model_mvx, model_mvy); else passed++;
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      ref_data_i  = '0;
      srch_data_i = '0;
      test_reset();
      test_all_zero();
      test_planted_match();
      test_max_diff();
      test_random();
      test_extra_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
